// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/CMD/LEN/payload/XOR frame parser behind the UART receiver
// Optional inter-byte timeout is enabled by defining UART_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int         MAX_LEN        = 8,
  parameter logic [7:0] SOF            = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rcv,
  input  logic [7:0]                   data_rx,
  output logic                         frame_valid,
  output logic [7:0]                   cmd,
  output logic [$clog2(MAX_LEN+1)-1:0] len,
  output logic [8*MAX_LEN-1:0]         payload,
  output logic                         frame_err,
  output logic [1:0]                   err_code,
  output logic                         busy
);
  localparam int LW = $clog2(MAX_LEN+1);
  localparam int PW = 8*MAX_LEN;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK} state_t;

  state_t        state_q, state_d;
  logic          rcv_q;
  logic          accept;
  logic          expire;

  logic [7:0]    cmd_sh_q, cmd_sh_d;
  logic [LW-1:0] len_sh_q, len_sh_d;
  logic [PW-1:0] pay_sh_q, pay_sh_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;

  logic [7:0]    cmd_q, cmd_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-1:0] pay_q, pay_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, busy_d;

  // Rising edge of rcv only, so a strobe held high yields a single byte.
  assign accept = rcv & ~rcv_q;

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] tmo_q, tmo_d;

  assign expire = (state_q != S_IDLE) && !accept && (tmo_q == CW'(TIMEOUT_CYCLES-1));
  assign tmo_d  = (accept || state_d == S_IDLE) ? '0 : tmo_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_sh_d = cmd_sh_q;
    len_sh_d = len_sh_q;
    pay_sh_d = pay_sh_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    pay_d    = pay_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;

    if (expire) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (data_rx == SOF) state_d = S_CMD;
        end
        S_CMD: begin
          cmd_sh_d = data_rx;
          xor_d    = data_rx;
          state_d  = S_LEN;
        end
        S_LEN: begin
          if (data_rx > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_IDLE;
          end else begin
            // Cleared for empty frames too, so unused payload bytes read as 0.
            len_sh_d = data_rx[LW-1:0];
            xor_d    = xor_q ^ data_rx;
            pay_sh_d = '0;
            idx_d    = '0;
            state_d  = (data_rx == 8'd0) ? S_CHK : S_DATA;
          end
        end
        S_DATA: begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == LW'(i)) pay_sh_d[8*i +: 8] = data_rx;
          end
          xor_d = xor_q ^ data_rx;
          idx_d = idx_q + LW'(1);
          if (idx_q + LW'(1) == len_sh_q) state_d = S_CHK;
        end
        S_CHK: begin
          if (data_rx == xor_q) begin
            cmd_d   = cmd_sh_q;
            len_d   = len_sh_q;
            pay_d   = pay_sh_q;
            valid_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rcv_q    <= 1'b0;
      cmd_sh_q <= '0;
      len_sh_q <= '0;
      pay_sh_q <= '0;
      idx_q    <= '0;
      xor_q    <= '0;
      cmd_q    <= '0;
      len_q    <= '0;
      pay_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcv_q    <= rcv;
      cmd_sh_q <= cmd_sh_d;
      len_sh_q <= len_sh_d;
      pay_sh_q <= pay_sh_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      pay_q    <= pay_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign cmd         = cmd_q;
  assign len         = len_q;
  assign payload     = pay_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
  localparam int         MAX_LEN = 8;
  localparam int         LW      = $clog2(MAX_LEN+1);
  localparam int         PW      = 8*MAX_LEN;
  localparam logic [7:0] SOF     = 8'hAA;
  localparam int         TMO     = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rcv = 1'b0;
  logic [7:0]    data_rx = 8'h00;
  logic          frame_valid, frame_err, busy;
  logic [7:0]    cmd;
  logic [LW-1:0] len;
  logic [PW-1:0] payload;
  logic [1:0]    err_code;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .SOF(SOF), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rcv(rcv), .data_rx(data_rx),
    .frame_valid(frame_valid), .cmd(cmd), .len(len), .payload(payload),
    .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [1:0]    code;
    logic [7:0]    cmd;
    logic [LW-1:0] len;
    logic [PW-1:0] pay;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [7:0]    good_cmd = '0;
  logic [LW-1:0] good_len = '0;
  logic [PW-1:0] good_pay = '0;
  logic [1:0]    last_code = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs at the pulse: the last good frame, and the last discard reason.
  task automatic push_exp(input bit is_err, input logic [1:0] code, input int at);
    exp_t e;
    if (is_err) last_code = code;
    e.is_err = is_err;
    e.code   = last_code;
    e.cmd    = good_cmd;
    e.len    = good_len;
    e.pay    = good_pay;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      check("pulse_exclusive", 64'(frame_valid & frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none", frame_valid, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 64'({frame_valid, frame_err}), mon_e.is_err ? 64'd1 : 64'd2);
        check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("err_code", 64'(err_code), 64'(mon_e.code));
        check("cmd", 64'(cmd), 64'(mon_e.cmd));
        check("len", 64'(len), 64'(mon_e.len));
        check("payload", 64'(payload), 64'(mon_e.pay));
      end
    end
  end

  // Called at a negedge; returns at a negedge with rcv low.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    int h, g;
    h = (hold > 0) ? hold : int'($urandom_range(1, 4));
    g = (gap > 0) ? gap : int'($urandom_range(1, 3));
    data_rx = b;
    rcv = 1'b1;
    repeat (h) @(negedge clk);
    rcv = 1'b0;
    data_rx = 8'($urandom());
    repeat (g) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] l, input logic [PW-1:0] pl,
                            input logic [7:0] bad, input int hold);
    logic [7:0]    chk;
    logic [PW-1:0] pm;
    send_byte(SOF, hold, 0);
    check("busy_in_frame", 64'(busy), 64'd1);
    send_byte(c, hold, 0);
    if (l > 8'(MAX_LEN)) begin
      push_exp(1'b1, 2'd1, cyc + 1);
      send_byte(l, hold, 0);
      check("busy_after_len_err", 64'(busy), 64'd0);
      return;
    end
    send_byte(l, hold, 0);
    chk = c ^ l;
    pm  = '0;
    for (int i = 0; i < int'(l); i++) begin
      chk ^= pl[8*i +: 8];
      pm[8*i +: 8] = pl[8*i +: 8];
      send_byte(pl[8*i +: 8], hold, 0);
    end
    if (bad == 8'h00) begin
      good_cmd = c;
      good_len = l[LW-1:0];
      good_pay = pm;
      push_exp(1'b0, 2'd0, cyc + 1);
    end else begin
      push_exp(1'b1, 2'd2, cyc + 1);
    end
    send_byte(chk ^ bad, hold, 0);
    check("busy_after_frame", 64'(busy), 64'd0);
  endtask

  logic [7:0]    rb, rc;
  logic [PW-1:0] rp;
  int            kind, nn;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(frame_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_err", 64'(frame_err), 64'd0);
    check("rst_code", 64'(err_code), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_len", 64'(len), 64'd0);
    check("rst_payload", 64'(payload), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    send_frame(8'h10, 8'h02, 64'h3231, 8'h00, 0);
    check("tp_good_payload", 64'(payload), 64'h3231);
    send_frame(8'h10, 8'h02, 64'h3231, 8'h03, 0);
    check("tp_badchk_holds_cmd", 64'(cmd), 64'h10);
    send_frame(8'h20, 8'h09, 64'h0, 8'h00, 0);
    send_frame(8'h05, 8'h00, 64'h0, 8'h00, 0);
    check("tp_empty_len", 64'(len), 64'd0);

    send_byte(8'h55, 5, 0);
    send_byte(8'h00, 5, 0);
    send_frame(8'h10, 8'h01, 64'hAA, 8'h00, 5);
    check("tp_held_payload", 64'(payload), 64'hAA);

    send_byte(SOF, 0, 0);
    send_byte(8'h10, 0, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h31, 0, 0);
    rst = 1'b1;
    good_cmd = '0;
    good_len = '0;
    good_pay = '0;
    last_code = '0;
    repeat (2) @(negedge clk);
    check("midrst_cmd", 64'(cmd), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_code", 64'(err_code), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h10, 8'h02, 64'h3231, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      nn   = int'($urandom_range(0, 2));
      for (int k = 0; k < nn; k++) begin
        rb = 8'($urandom());
        if (rb == SOF) rb = 8'h00;
        send_byte(rb, 0, 0);
      end
      rc = 8'($urandom());
      rp = {$urandom(), $urandom()};
      if (kind < 6)
        send_frame(rc, 8'($urandom_range(0, MAX_LEN)), rp, 8'h00, 0);
      else if (kind < 8)
        send_frame(rc, 8'($urandom_range(0, MAX_LEN)), rp, 8'($urandom_range(1, 255)), 0);
      else
        send_frame(rc, 8'($urandom_range(MAX_LEN + 1, 255)), rp, 8'h00, 0);
    end

`ifdef UART_PARSER_TIMEOUT_EN
    send_byte(SOF, 1, 1);
    push_exp(1'b1, 2'd3, cyc + 1 + TMO);
    send_byte(8'h10, 1, 1);
    repeat (TMO + 5) @(negedge clk);
    check("busy_after_timeout", 64'(busy), 64'd0);
    send_byte(SOF, 1, 1);
    send_byte(8'h10, 1, 1);
    send_byte(8'h02, 1, TMO - 2);
    send_byte(8'h31, 1, 1);
    send_byte(8'h32, 1, 1);
    good_cmd = 8'h10;
    good_len = LW'(2);
    good_pay = 64'h3231;
    push_exp(1'b0, 2'd0, cyc + 1);
    send_byte(8'h11, 1, 1);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
